// File: rtl/subdiv_pkg.sv
// Shared types and fixed-point constants for the Loop-subdivision vertex smoothing pass.
package subdiv_pkg;

  localparam int FRAC_BITS    = 16;
  localparam int ADDR_W       = 9;
  localparam int VERTEX_WORDS = 3;
  localparam int ACC_W        = 36;
  localparam int PROD_W       = 54;

  localparam logic [16:0] Q_ONE      = 17'h10000;
  localparam logic [31:0] ROUND_HALF = 32'(1) << (FRAC_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_VCOUNT = 4'd1,
    S_WR_VCOUNT = 4'd2,
    S_RD_CENTER = 4'd3,
    S_RD_NCOUNT = 4'd4,
    S_RD_NIDX   = 4'd5,
    S_RD_NPOS   = 4'd6,
    S_COMPUTE   = 4'd7,
    S_WRITE     = 4'd8,
    S_NEXT      = 4'd9,
    S_DONE      = 4'd10
  } state_e;

endpackage

// File: rtl/vertex_smooth_if.sv
// Control and RAM port bundle of vertex_smooth; master is the smoothing engine, slave the RAM/host side.
// Handshake: start is a single-cycle pulse honoured only when busy is low; RAM reads return one cycle after A.
interface vertex_smooth_if;
  import subdiv_pkg::*;

  logic                start;
  logic                busy;
  logic                done;
  state_e              dbg_state;

  logic                RAM1_EN;
  logic [ADDR_W-1:0]   RAM1_A;
  logic [3:0]          RAM1_WE;
  logic [31:0]         RAM1_Di;
  logic [31:0]         RAM1_Do;

  logic                RAM2_EN;
  logic [ADDR_W-1:0]   RAM2_A;
  logic [3:0]          RAM2_WE;
  logic [31:0]         RAM2_Di;
  logic [31:0]         RAM2_Do;

  logic                RAM3_EN;
  logic [ADDR_W-1:0]   RAM3_A;
  logic [3:0]          RAM3_WE;
  logic [31:0]         RAM3_Di;

  modport master (
    input  start, RAM1_Do, RAM2_Do,
    output busy, done, dbg_state,
    output RAM1_EN, RAM1_A, RAM1_WE, RAM1_Di,
    output RAM2_EN, RAM2_A, RAM2_WE, RAM2_Di,
    output RAM3_EN, RAM3_A, RAM3_WE, RAM3_Di
  );

  modport slave (
    output start, RAM1_Do, RAM2_Do,
    input  busy, done, dbg_state,
    input  RAM1_EN, RAM1_A, RAM1_WE, RAM1_Di,
    input  RAM2_EN, RAM2_A, RAM2_WE, RAM2_Di,
    input  RAM3_EN, RAM3_A, RAM3_WE, RAM3_Di
  );
endinterface

// File: rtl/vertex_smooth_loop_weight_lut.sv
// Loop even-vertex weights: beta(n) in Q0.16 and alpha(n) = 1 - n*beta(n) as unsigned 17 bits.
module loop_weight_lut
  import subdiv_pkg::*;
(
    input  logic [3:0]  i_n,
    output logic [15:0] o_beta,
    output logic [16:0] o_alpha
);

    logic [16:0] w_nbeta;

    // floor(3/(8n) * 2^16), except the n==3 special case of 3/16
    always_comb begin
        o_beta = 16'd0;
        case (i_n)
            4'd1:    o_beta = 16'd24576;
            4'd2:    o_beta = 16'd12288;
            4'd3:    o_beta = 16'd12288;
            4'd4:    o_beta = 16'd6144;
            4'd5:    o_beta = 16'd4915;
            4'd6:    o_beta = 16'd4096;
            4'd7:    o_beta = 16'd3510;
            4'd8:    o_beta = 16'd3072;
            4'd9:    o_beta = 16'd2730;
            4'd10:   o_beta = 16'd2457;
            4'd11:   o_beta = 16'd2234;
            4'd12:   o_beta = 16'd2048;
            4'd13:   o_beta = 16'd1890;
            4'd14:   o_beta = 16'd1755;
            4'd15:   o_beta = 16'd1638;
            default: o_beta = 16'd0;
        endcase
    end

    assign w_nbeta = {13'd0, i_n} * {1'b0, o_beta};
    assign o_alpha = Q_ONE - w_nbeta;

endmodule

// File: rtl/vertex_smooth.sv
// Loop-subdivision even-vertex repositioning pass: new = alpha(n)*v + beta(n)*sum(neighbours).
// Build option SMOOTH_ROUND_EN: round half-up before the fractional shift instead of flooring.
module vertex_smooth
  import subdiv_pkg::*;
#(
    parameter int NEIGHBOR_STRIDE = 10
)(
    input  logic clk,
    input  logic rst,
    vertex_smooth_if.master bus
);

    localparam logic [3:0] NMAX = 4'(NEIGHBOR_STRIDE - 1);

    state_e                    r_state;
    logic [1:0]                r_sub;
    logic [ADDR_W-1:0]         r_k;
    logic [31:0]               r_vcount;
    logic [3:0]                r_n;
    logic [3:0]                r_j;
    logic [31:0]               r_nidx;
    logic signed [31:0]        r_v   [VERTEX_WORDS];
    logic signed [ACC_W-1:0]   r_acc [VERTEX_WORDS];

    logic [ADDR_W-1:0]         w_vbase;
    logic [ADDR_W-1:0]         w_nbase;
    logic [ADDR_W-1:0]         w_npos_base;
    logic [31:0]               w_idx;
    logic [3:0]                w_cnt;
    logic signed [ACC_W-1:0]   w_do1_ext;
    logic [15:0]               w_beta;
    logic [16:0]               w_alpha;
    logic signed [31:0]        w_v_sel;
    logic signed [ACC_W-1:0]   w_acc_sel;
    logic signed [PROD_W-1:0]  w_a54, w_b54, w_v54, w_s54, w_sum;

    loop_weight_lut u_lut (
        .i_n     (r_n),
        .o_beta  (w_beta),
        .o_alpha (w_alpha)
    );

    assign w_vbase     = ADDR_W'((r_k - 9'd1) * 9'd3 + 9'd1);
    assign w_nbase     = ADDR_W'((int'(r_k) - 1) * NEIGHBOR_STRIDE);
    // The neighbour index arrives on RAM2_Do in the first position-read cycle and is held after that
    assign w_idx       = (r_state == S_RD_NPOS && r_sub == 2'd0) ? bus.RAM2_Do : r_nidx;
    assign w_npos_base = ADDR_W'((w_idx - 32'd1) * 32'd3 + 32'd1);
    assign w_cnt       = (bus.RAM2_Do[3:0] > NMAX) ? NMAX : bus.RAM2_Do[3:0];
    assign w_do1_ext   = {{(ACC_W-32){bus.RAM1_Do[31]}}, bus.RAM1_Do};

    always_comb begin
        w_v_sel   = r_v[0];
        w_acc_sel = r_acc[0];
        case (r_sub)
            2'd1:    begin w_v_sel = r_v[1]; w_acc_sel = r_acc[1]; end
            2'd2:    begin w_v_sel = r_v[2]; w_acc_sel = r_acc[2]; end
            default: begin w_v_sel = r_v[0]; w_acc_sel = r_acc[0]; end
        endcase
    end

    assign w_a54 = {{(PROD_W-17){1'b0}}, w_alpha};
    assign w_b54 = {{(PROD_W-16){1'b0}}, w_beta};
    assign w_v54 = {{(PROD_W-32){w_v_sel[31]}}, w_v_sel};
    assign w_s54 = {{(PROD_W-ACC_W){w_acc_sel[ACC_W-1]}}, w_acc_sel};
`ifdef SMOOTH_ROUND_EN
    assign w_sum = w_a54 * w_v54 + w_b54 * w_s54 + {{(PROD_W-32){1'b0}}, ROUND_HALF};
`else
    assign w_sum = w_a54 * w_v54 + w_b54 * w_s54;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sub    <= 2'd0;
            r_k      <= '0;
            r_vcount <= '0;
            r_n      <= '0;
            r_j      <= '0;
            r_nidx   <= '0;
            for (int i = 0; i < VERTEX_WORDS; i++) begin
                r_v[i]   <= '0;
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (bus.start) r_state <= S_RD_VCOUNT;
                S_RD_VCOUNT: r_state <= S_WR_VCOUNT;
                S_WR_VCOUNT: begin
                    r_vcount <= bus.RAM1_Do;
                    r_k      <= 9'd1;
                    r_sub    <= 2'd0;
                    r_state  <= (bus.RAM1_Do == 32'd0) ? S_DONE : S_RD_CENTER;
                end
                S_RD_CENTER: begin
                    r_sub <= r_sub + 2'd1;
                    if (r_sub == 2'd0) begin
                        r_j <= '0;
                        for (int i = 0; i < VERTEX_WORDS; i++) r_acc[i] <= '0;
                    end
                    if (r_sub == 2'd1) r_v[0] <= bus.RAM1_Do;
                    if (r_sub == 2'd2) begin
                        r_v[1]  <= bus.RAM1_Do;
                        r_sub   <= 2'd0;
                        r_state <= S_RD_NCOUNT;
                    end
                end
                S_RD_NCOUNT: begin
                    r_v[2]  <= bus.RAM1_Do;
                    r_state <= S_RD_NIDX;
                end
                S_RD_NIDX: begin
                    r_sub <= 2'd0;
                    // First visit sees the count word; later visits see the previous neighbour's z
                    if (r_j == 4'd0) begin
                        r_n     <= w_cnt;
                        r_state <= (w_cnt == 4'd0) ? S_COMPUTE : S_RD_NPOS;
                    end else begin
                        r_acc[2] <= r_acc[2] + w_do1_ext;
                        r_state  <= S_RD_NPOS;
                    end
                end
                S_RD_NPOS: begin
                    r_sub <= r_sub + 2'd1;
                    if (r_sub == 2'd0) r_nidx <= bus.RAM2_Do;
                    if (r_sub == 2'd1) r_acc[0] <= r_acc[0] + w_do1_ext;
                    if (r_sub == 2'd2) begin
                        r_acc[1] <= r_acc[1] + w_do1_ext;
                        r_j      <= r_j + 4'd1;
                        r_sub    <= 2'd0;
                        r_state  <= (r_j + 4'd1 == r_n) ? S_COMPUTE : S_RD_NIDX;
                    end
                end
                S_COMPUTE: begin
                    if (r_n != 4'd0) r_acc[2] <= r_acc[2] + w_do1_ext;
                    r_sub   <= 2'd0;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_sub <= r_sub + 2'd1;
                    if (r_sub == 2'd2) begin
                        r_sub   <= 2'd0;
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if ({23'd0, r_k} == r_vcount) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k + 9'd1;
                        r_state <= S_RD_CENTER;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.RAM1_A  = '0;
        bus.RAM2_A  = '0;
        bus.RAM3_A  = '0;
        bus.RAM3_Di = '0;
        bus.RAM3_WE = 4'b0000;
        case (r_state)
            S_RD_CENTER: bus.RAM1_A = w_vbase + ADDR_W'(r_sub);
            S_RD_NPOS:   bus.RAM1_A = w_npos_base + ADDR_W'(r_sub);
            S_RD_NCOUNT: bus.RAM2_A = w_nbase;
            S_RD_NIDX:   bus.RAM2_A = w_nbase + ADDR_W'(r_j) + 9'd1;
            S_WR_VCOUNT: begin
                bus.RAM3_Di = bus.RAM1_Do;
                bus.RAM3_WE = rst ? 4'b0000 : 4'b1111;
            end
            S_WRITE: begin
                bus.RAM3_A  = w_vbase + ADDR_W'(r_sub);
                bus.RAM3_Di = 32'(w_sum >>> FRAC_BITS);
                bus.RAM3_WE = rst ? 4'b0000 : 4'b1111;
            end
            default: ;
        endcase
    end

    assign bus.RAM1_EN   = 1'b1;
    assign bus.RAM1_WE   = 4'b0000;
    assign bus.RAM1_Di   = '0;
    assign bus.RAM2_EN   = 1'b1;
    assign bus.RAM2_WE   = 4'b0000;
    assign bus.RAM2_Di   = '0;
    assign bus.RAM3_EN   = 1'b1;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.dbg_state = r_state;

endmodule

// File: doc/vertex_smooth.md
Name: vertex_smooth

Overview:
- Downstream stage of the neighbour-list builder. Runs the Loop-subdivision even-vertex repositioning pass.
- For every original vertex it reads the vertex position from the obj RAM and the neighbour list from the neighbour RAM, then fetches each neighbour's position.
- Computes new = alpha(n)*v + beta(n)*sum(neighbours) and writes the result to an output vertex RAM.
- Runs once per start pulse, after the neighbour builder has finished.

Parameters:
- NEIGHBOR_STRIDE, 10: words per vertex neighbour list. Word 0 is the count; words 1..count are 1-based vertex indices.
- FRAC_BITS, 16: fractional bits of signed Q16.16 coordinates and of the Q0.16 weights.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- busy  out  1  high from the cycle after start until DONE
- done  out  1  high in DONE; held until the next start or rst
- RAM1_EN, RAM1_A[8:0], RAM1_WE[3:0], RAM1_Di[31:0]  out  obj RAM port (read only: WE=0, Di=0)
- RAM1_Do  in  32  obj RAM read data
- RAM2_EN, RAM2_A[8:0], RAM2_WE[3:0], RAM2_Di[31:0]  out  neighbour RAM port (read only)
- RAM2_Do  in  32  neighbour RAM read data
- RAM3_EN, RAM3_A[8:0], RAM3_WE[3:0], RAM3_Di[31:0]  out  output vertex RAM port (write only)

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state IDLE; busy=0, done=0; all EN=1, all A=0, all WE=0, all Di=0.
- RAM latency: read data is valid on Do one cycle after A is driven. Writes commit on the clock edge where WE=4'b1111.
- Memory layout:
  - obj RAM: addr 0 holds vcount; vertex k (1-based) x/y/z at 3(k-1)+1, +2, +3.
  - neighbour RAM: list base for vertex k is (k-1)*NEIGHBOR_STRIDE.
  - output RAM: same layout as obj RAM; addr 0 is written with vcount.
- FSM states: IDLE, RD_VCOUNT, WR_VCOUNT, RD_CENTER (3 reads), RD_NCOUNT, RD_NIDX, RD_NPOS (3 reads), COMPUTE, WRITE (3 writes), NEXT, DONE.
- Transitions:
  - IDLE/DONE → RD_VCOUNT on start.
  - RD_VCOUNT → WR_VCOUNT.
  - If vcount==0, go straight to DONE after WR_VCOUNT.
  - Per vertex: RD_CENTER → RD_NCOUNT → (RD_NIDX → RD_NPOS) × n → COMPUTE → WRITE → NEXT.
  - NEXT: k==vcount → DONE; otherwise k+1 → RD_CENTER.
- Neighbour count n = RAM2_Do[3:0], clamped to NEIGHBOR_STRIDE-1; upper bits ignored.
  - n==0: skip all neighbour reads; output = input position.
- Weights come from loop_weight_lut:
  - beta = 3/16 for n==3, otherwise floor(3/(8n)*2^16), for n in 1..15.
  - alpha = 2^16 - n*beta, held as unsigned 17 bits.
  - n==0: alpha=2^16, beta=0.
- Arithmetic:
  - Per-axis accumulator is 36-bit signed, sign-extended.
  - Products are signed, at least 54 bits.
  - Result per axis = (alpha*v + beta*sum) >>> FRAC_BITS (arithmetic shift), truncated to 32 bits.
  - No saturation.
- Output RAM3_A is only ever 0 or 3(k-1)+1..+3. RAM1/RAM2 never write.
- A start received while busy is ignored.
- rst mid-operation: next cycle is IDLE with reset outputs; any write in flight on that edge is suppressed (WE=0).
- done deasserts in the cycle after a start accepted from DONE.

Optional Feature:
- Macro: SMOOTH_ROUND_EN.
- Defined: add 2^(FRAC_BITS-1) to the pre-shift sum, giving round-half-up.
- Undefined: plain truncation (floor).

Decomposition:
- Package subdiv_pkg holds:
  - the FSM state enum
  - FRAC_BITS and the Q-format constants
  - the RAM address-width constant (9)
  - the VERTEX_WORDS=3 layout constant
- Sub-module loop_weight_lut: combinational, 4-bit n in → 16-bit beta and 17-bit alpha out.

Test Plan:
- Single vertex, origin, 3 neighbours at unit x/y/z (x=0x00010000 etc.), start → output addr0=1; addr1..3 = 0x00003000 each; done=1; busy=0.
- Invariance: vertex (0x10000,0x10000,0x10000) with 6 neighbours all equal to it → output unchanged, 0x00010000 per axis (alpha=0xA000, beta=0x1000).
- n==0 vertex at (0x12345678, 0xFFFF0000, 0x7) → copied exactly; no RAM1 reads beyond its own 3 words.
- Count word 0x0000000F with NEIGHBOR_STRIDE=10 → exactly 9 neighbour indices fetched; result matches n=9 weights.
- vcount=0 → only addr0=0 written; done asserted within 4 cycles of start.
- Mid-run effects:
  - rst during WRITE of vertex 2 → RAM3_WE=0 the next cycle, busy=0, done=0.
  - A later start rewrites all vertices correctly.
  - Start pulse while busy → no restart; final output is identical to an undisturbed run.
